// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_master_bridge                                            |
// | Description : APB4 requester. Turns single valid/ready commands into       |
// |               SETUP/ACCESS transfers and returns a held response.          |
// |               Optional ACCESS timeout: define APB_MASTER_TIMEOUT_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_STRB  = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_STRB-1:0]  cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [2:0]            pprot,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_STRB-1:0]  pstrb,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  w_psel;
  logic                  w_penable;
  logic                  w_cmd_ready;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;

  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [2:0]            r_pprot;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_STRB-1:0]  r_pstrb;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  assign w_accept = cmd_valid && w_cmd_ready;
  assign w_done   = (r_state == c_ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  logic [c_CNT_W-1:0] r_wait_cnt;

  // Counts completed ACCESS cycles without pready; restarts on every SETUP.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == c_ACCESS) && !pready) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == c_ACCESS) && !pready &&
                     (r_wait_cnt == c_CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_accept) w_state_nxt = c_SETUP;
      c_SETUP:  w_state_nxt = c_ACCESS;
      c_ACCESS: if (w_done || w_timeout) w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // A pending response may be consumed in the same cycle a new command is taken.
  always_comb begin
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_cmd_ready = 1'b0;
    case (r_state)
      c_IDLE:   w_cmd_ready = !r_rsp_valid || rsp_ready;
      c_SETUP:  w_psel      = 1'b1;
      c_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
      end
      default:  w_cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_paddr  <= '0;
      r_pprot  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_accept) begin
      r_paddr  <= cmd_addr;
      r_pprot  <= cmd_prot;
      r_pwrite <= cmd_write;
      r_pwdata <= cmd_wdata;
      r_pstrb  <= cmd_write ? cmd_strb : '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= r_pwrite ? '0 : prdata;
      r_rsp_err   <= pslverr;
    end else if (w_timeout) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b1;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready = w_cmd_ready && nrst;
  assign psel      = w_psel;
  assign penable   = w_penable;
  assign paddr     = r_paddr;
  assign pprot     = r_pprot;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
